// File: rtl/data_sram_req_gen_if.sv
// Data-SRAM-like bus between the load/store request generator (master) and memory (slave).
interface data_sram_req_gen_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req,
        output wr,
        output size,
        output addr,
        output wstrb,
        output wdata,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  wr,
        input  size,
        input  addr,
        input  wstrb,
        input  wdata,
        output addr_ok,
        output data_ok,
        output rdata
    );
endinterface

// File: rtl/data_sram_req_gen.sv
// Data-SRAM initiator: holds one request until addr_ok, builds store strobes/lanes,
// counts outstanding transactions and drops responses of flushed operations.
module data_sram_req_gen #(
    parameter int  MAX_OUTSTANDING = 2,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic                 op_store,
    input  logic [1:0]           op_size,
    input  logic [31:0]          op_addr,
    input  logic [31:0]          op_wdata,
    data_sram_req_gen_if.master  data_sram,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_ale,
    output logic [CW-1:0]        dbg_outstanding,
    output logic [CW-1:0]        dbg_discard
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE     = CW'(1);

    // Handshakes: an op transfers when op_valid & op_ready; a bus request transfers
    // when req & addr_ok, with req and all its fields held stable until then;
    // data_ok is one in-order response and resp_valid has no backpressure.

    logic          req_pending;
    logic          req_wr;
    logic [1:0]    req_size;
    logic [31:0]   req_addr;
    logic [3:0]    req_wstrb;
    logic [31:0]   req_wdata;
    logic          ale_pending;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic          op_misaligned;
    logic [3:0]    op_wstrb;
    logic [31:0]   op_lane_data;
    logic          op_fire;
    logic          addr_hs;
    logic          rsp_hs;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard_next;

    always_comb begin
        op_misaligned = 1'b0;
        case (op_size)
            2'd0:    op_misaligned = 1'b0;
            2'd1:    op_misaligned = op_addr[0];
            default: op_misaligned = |op_addr[1:0];
        endcase
    end

    // Size 3 is illegal and behaves as a word access.
    always_comb begin
        op_wstrb     = 4'b0000;
        op_lane_data = 32'h0;
        if (op_store) begin
            case (op_size)
                2'd0: begin
                    op_wstrb     = 4'b0001 << op_addr[1:0];
                    op_lane_data = {4{op_wdata[7:0]}};
                end
                2'd1: begin
                    op_wstrb     = 4'b0011 << op_addr[1:0];
                    op_lane_data = {2{op_wdata[15:0]}};
                end
                default: begin
                    op_wstrb     = 4'b1111;
                    op_lane_data = op_wdata;
                end
            endcase
        end
    end

    // A misaligned op answers immediately, so it must wait until no bus response
    // (live or discarded) is still due, keeping responses in order.
    always_comb begin
        op_ready = ~req_pending & ~ale_pending & (outstanding < MAX_CNT) & ~flush;
        if (op_misaligned && (outstanding != '0 || discard != '0)) begin
            op_ready = 1'b0;
        end
    end

    assign op_fire = op_valid & op_ready;
    assign addr_hs = req_pending & data_sram.addr_ok;
    assign rsp_hs  = data_sram.data_ok & (outstanding != '0);

    always_comb begin
        outstanding_next = outstanding;
        if (addr_hs && !rsp_hs) begin
            outstanding_next = outstanding + ONE;
        end else if (!addr_hs && rsp_hs) begin
            outstanding_next = outstanding - ONE;
        end
    end

    // On flush every transaction still owed a response is discarded, including a
    // pending request that has not been accepted yet (it is never withdrawn).
    always_comb begin
        discard_next = discard;
        if (flush) begin
            discard_next = outstanding_next + CW'(req_pending & ~data_sram.addr_ok);
        end else if (rsp_hs && discard != '0) begin
            discard_next = discard - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_pending <= 1'b0;
            req_wr      <= 1'b0;
            req_size    <= 2'd0;
            req_addr    <= 32'h0;
            req_wstrb   <= 4'b0000;
            req_wdata   <= 32'h0;
            ale_pending <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            discard     <= discard_next;
            ale_pending <= op_fire & op_misaligned & ~flush;
            if (addr_hs) begin
                req_pending <= 1'b0;
                req_wr      <= 1'b0;
                req_size    <= 2'd0;
                req_addr    <= 32'h0;
                req_wstrb   <= 4'b0000;
                req_wdata   <= 32'h0;
            end else if (op_fire && !op_misaligned) begin
                req_pending <= 1'b1;
                req_wr      <= op_store;
                req_size    <= op_size;
                req_addr    <= op_addr;
                req_wstrb   <= op_wstrb;
                req_wdata   <= op_lane_data;
            end
        end
    end

    assign data_sram.req   = req_pending;
    assign data_sram.wr    = req_wr;
    assign data_sram.size  = req_size;
    assign data_sram.addr  = req_addr;
    assign data_sram.wstrb = req_wstrb;
    assign data_sram.wdata = req_wdata;

    assign resp_valid      = (data_sram.data_ok & (discard == '0)) | ale_pending;
    assign resp_ale        = ale_pending;
    assign resp_rdata      = data_sram.rdata;

    assign dbg_outstanding = outstanding;
    assign dbg_discard     = discard;

endmodule

// File: tb/tb_data_sram_req_gen.sv
// Bench for data_sram_req_gen: vector table, hand sequences, then random traffic vs a queue model.
module tb_data_sram_req_gen;
  localparam int MAX = 2;
  localparam int CW = $clog2(MAX + 1);

  logic clk = 1'b0;
  logic reset, flush, op_valid, op_ready, op_store;
  logic [1:0] op_size;
  logic [31:0] op_addr, op_wdata;
  logic resp_valid, resp_ale;
  logic [31:0] resp_rdata;
  logic [CW-1:0] dbg_outstanding, dbg_discard;
  int checks = 0;
  int failures = 0;

  data_sram_req_gen_if bus();

  data_sram_req_gen #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready), .op_store(op_store),
    .op_size(op_size), .op_addr(op_addr), .op_wdata(op_wdata),
    .data_sram(bus.master),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ale(resp_ale),
    .dbg_outstanding(dbg_outstanding), .dbg_discard(dbg_discard)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference rules
  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return addr[0];
    return addr[1:0] != 2'd0;
  endfunction

  function automatic logic [3:0] strb_of(input logic st, input logic [1:0] size, input logic [31:0] addr);
    int unsigned m;
    if (!st) return 4'd0;
    if (size >= 2'd2) return 4'hF;
    m = (size == 2'd0) ? 1 : 3;
    return 4'(m * (2 ** addr[1:0]));
  endfunction

  function automatic logic [31:0] lane_of(input logic st, input logic [1:0] size, input logic [31:0] w);
    if (!st) return 32'h0;
    if (size == 2'd0) return 32'(w[7:0]) * 32'h0101_0101;
    if (size == 2'd1) return 32'(w[15:0]) * 32'h0001_0001;
    return w;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    flush = 1'b0; op_valid = 1'b0; op_store = 1'b0; op_size = 2'd0;
    op_addr = 32'h0; op_wdata = 32'h0;
    bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = 32'h0;
  endtask

  task automatic respond(input logic [31:0] rd, input logic exp_valid, input string tag);
    chk({tag, "_prot_outstanding_nonzero"}, 32'(dbg_outstanding != '0), 32'd1);
    bus.data_ok = 1'b1;
    bus.rdata = rd;
    #2;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk({tag, "_resp_rdata"}, resp_rdata, rd);
      chk({tag, "_resp_ale"}, 32'(resp_ale), 32'd0);
    end
    tick();
    bus.data_ok = 1'b0;
    #2;
  endtask

  task automatic issue_load(input logic [31:0] addr);
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'd2; op_addr = addr;
    tick();
    op_valid = 1'b0;
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0;
    #2;
  endtask

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ale;
    logic [3:0]  strb;
    logic [31:0] lane;
  } vec_t;

  vec_t vecs[10];

  // scoreboard: one entry per accepted bus transaction, 1 = response delivered
  logic [0:0] exp_q[$];
  bit pend_v, pend_k, pend_store, ale_m;
  logic [1:0] pend_size;
  logic [31:0] pend_addr, pend_wdata;

  initial begin
    vecs[0] = '{1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB};
    vecs[1] = '{1'b1, 2'd1, 32'h0000_2002, 32'h1234_CDEF, 1'b0, 4'b1100, 32'hCDEF_CDEF};
    vecs[2] = '{1'b1, 2'd2, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 2'd2, 32'h0000_2000, 32'hFFFF_FFFF, 1'b0, 4'b0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 2'd0, 32'h0000_5001, 32'h0000_0077, 1'b0, 4'b0010, 32'h7777_7777};
    vecs[5] = '{1'b0, 2'd1, 32'h0000_3001, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000};
    vecs[6] = '{1'b0, 2'd2, 32'h0000_3002, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000};
    vecs[7] = '{1'b1, 2'd3, 32'h0000_0008, 32'h1122_3344, 1'b0, 4'b1111, 32'h1122_3344};
    vecs[8] = '{1'b1, 2'd1, 32'h0000_0007, 32'h0000_5555, 1'b1, 4'b0000, 32'h0000_0000};
    vecs[9] = '{1'b0, 2'd0, 32'h0000_0007, 32'h0000_0099, 1'b0, 4'b0000, 32'h0000_0000};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #2;
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_wr", 32'(bus.wr), 32'd0);
    chk("rst_size", 32'(bus.size), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_wstrb", 32'(bus.wstrb), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_outstanding", 32'(dbg_outstanding), 32'd0);
    chk("rst_discard", 32'(dbg_discard), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_ale", 32'(resp_ale), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd1);

    // vector table: addr_ok in the first request cycle, response next
    for (int i = 0; i < 10; i++) begin
      op_valid = 1'b1; op_store = vecs[i].store; op_size = vecs[i].size;
      op_addr = vecs[i].addr; op_wdata = vecs[i].wdata;
      #2;
      chk($sformatf("vec%0d_ready", i), 32'(op_ready), 32'd1);
      tick();
      op_valid = 1'b0;
      #2;
      if (vecs[i].ale) begin
        chk($sformatf("vec%0d_no_req", i), 32'(bus.req), 32'd0);
        chk($sformatf("vec%0d_ale_valid", i), 32'(resp_valid), 32'd1);
        chk($sformatf("vec%0d_ale", i), 32'(resp_ale), 32'd1);
        tick();
        #2;
        chk($sformatf("vec%0d_ale_one_cycle", i), 32'(resp_valid), 32'd0);
        chk($sformatf("vec%0d_ale_clear", i), 32'(resp_ale), 32'd0);
      end else begin
        chk($sformatf("vec%0d_req", i), 32'(bus.req), 32'd1);
        chk($sformatf("vec%0d_wr", i), 32'(bus.wr), 32'(vecs[i].store));
        chk($sformatf("vec%0d_size", i), 32'(bus.size), 32'(vecs[i].size));
        chk($sformatf("vec%0d_addr", i), bus.addr, vecs[i].addr);
        chk($sformatf("vec%0d_wstrb", i), 32'(bus.wstrb), 32'(vecs[i].strb));
        chk($sformatf("vec%0d_wdata", i), bus.wdata, vecs[i].lane);
        chk($sformatf("vec%0d_resp_idle", i), 32'(resp_valid), 32'd0);
        bus.addr_ok = 1'b1;
        tick();
        bus.addr_ok = 1'b0;
        #2;
        chk($sformatf("vec%0d_req_drop", i), 32'(bus.req), 32'd0);
        chk($sformatf("vec%0d_addr_clear", i), bus.addr, 32'd0);
        chk($sformatf("vec%0d_outstanding", i), 32'(dbg_outstanding), 32'd1);
        respond($urandom(), 1'b1, $sformatf("vec%0d", i));
      end
    end

    // load held while addr_ok is delayed 3 cycles
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'd2; op_addr = 32'h0000_2000;
    tick();
    op_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("hold%0d_req", k), 32'(bus.req), 32'd1);
      chk($sformatf("hold%0d_addr", k), bus.addr, 32'h0000_2000);
      chk($sformatf("hold%0d_size", k), 32'(bus.size), 32'd2);
      if (k == 3) bus.addr_ok = 1'b1;
      tick();
    end
    bus.addr_ok = 1'b0;
    #2;
    chk("hold_req_drop", 32'(bus.req), 32'd0);
    tick();
    respond(32'h1234_5678, 1'b1, "hold");

    // back-to-back loads saturate the outstanding limit
    issue_load(32'h100);
    issue_load(32'h104);
    chk("b2b_peak", 32'(dbg_outstanding), 32'd2);
    op_valid = 1'b1; op_addr = 32'h108;
    #1;
    chk("b2b_blocked0", 32'(op_ready), 32'd0);
    tick();
    #2;
    chk("b2b_blocked1", 32'(op_ready), 32'd0);
    chk("b2b_no_req", 32'(bus.req), 32'd0);
    respond(32'hA5A5_0001, 1'b1, "b2b_r0");
    chk("b2b_ready_after_data_ok", 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b0;
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0;
    #2;
    chk("b2b_refill", 32'(dbg_outstanding), 32'd2);
    respond(32'hA5A5_0002, 1'b1, "b2b_r1");
    respond(32'hA5A5_0003, 1'b1, "b2b_r2");
    chk("b2b_drained", 32'(dbg_outstanding), 32'd0);

    // flush with two issued loads
    issue_load(32'h200);
    issue_load(32'h204);
    flush = 1'b1;
    op_valid = 1'b1; op_addr = 32'h208;
    #1;
    chk("fl1_ready_low", 32'(op_ready), 32'd0);
    tick();
    flush = 1'b0;
    op_valid = 1'b0;
    #2;
    chk("fl1_discard", 32'(dbg_discard), 32'd2);
    respond(32'h1, 1'b0, "fl1_r0");
    chk("fl1_discard_dec", 32'(dbg_discard), 32'd1);
    respond(32'h2, 1'b0, "fl1_r1");
    chk("fl1_discard_zero", 32'(dbg_discard), 32'd0);
    issue_load(32'h20C);
    respond(32'h0BAD_F00D, 1'b1, "fl1_after");

    // flush with one issued and one request still waiting for addr_ok
    issue_load(32'h300);
    op_valid = 1'b1; op_addr = 32'h304;
    tick();
    op_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #2;
    chk("fl2_discard", 32'(dbg_discard), 32'd2);
    chk("fl2_req_kept", 32'(bus.req), 32'd1);
    chk("fl2_addr_kept", bus.addr, 32'h304);
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0;
    #2;
    chk("fl2_outstanding", 32'(dbg_outstanding), 32'd2);
    respond(32'h3, 1'b0, "fl2_r0");
    respond(32'h4, 1'b0, "fl2_r1");
    chk("fl2_discard_zero", 32'(dbg_discard), 32'd0);

    // data_ok in the flush cycle is delivered and not counted in discard
    issue_load(32'h400);
    issue_load(32'h404);
    flush = 1'b1;
    bus.data_ok = 1'b1; bus.rdata = 32'h7777_0000;
    #2;
    chk("fl3_same_cycle_valid", 32'(resp_valid), 32'd1);
    tick();
    flush = 1'b0;
    bus.data_ok = 1'b0;
    #2;
    chk("fl3_discard", 32'(dbg_discard), 32'd1);
    respond(32'h5, 1'b0, "fl3_r1");
    chk("fl3_discard_zero", 32'(dbg_discard), 32'd0);

    // reset with one issued load and a stalled store request
    issue_load(32'h500);
    op_valid = 1'b1; op_store = 1'b1; op_size = 2'd2; op_addr = 32'h504; op_wdata = 32'h1;
    tick();
    op_valid = 1'b0;
    #2;
    chk("rst2_req_before", 32'(bus.req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    chk("rst2_req", 32'(bus.req), 32'd0);
    chk("rst2_outstanding", 32'(dbg_outstanding), 32'd0);
    chk("rst2_discard", 32'(dbg_discard), 32'd0);
    chk("rst2_op_ready", 32'(op_ready), 32'd1);

    // random traffic vs transaction-queue model
    idle_inputs();
    exp_q.delete();
    pend_v = 0; pend_k = 0; ale_m = 0;
    pend_store = 0; pend_size = 2'd0; pend_addr = 32'h0; pend_wdata = 32'h0;
    tick();
    for (int n = 0; n < 3000; n++) begin
      int killed;
      bit mis, e_ready, e_resp, fire;
      flush = ($urandom_range(0, 19) == 0);
      op_valid = 1'($urandom_range(0, 1));
      op_store = 1'($urandom_range(0, 1));
      op_size = 2'($urandom_range(0, 3));
      op_addr = $urandom();
      op_wdata = $urandom();
      bus.addr_ok = 1'($urandom_range(0, 1));
      bus.data_ok = (exp_q.size() != 0) && ($urandom_range(0, 2) == 0);
      bus.rdata = $urandom();
      #2;
      killed = 0;
      foreach (exp_q[j]) if (exp_q[j] == 1'b0) killed++;
      mis = is_mis(op_size, op_addr);
      e_ready = !pend_v && !ale_m && (exp_q.size() < MAX) && !flush &&
                (!mis || (exp_q.size() == 0 && killed == 0));
      e_resp = (bus.data_ok && exp_q[0] == 1'b1) || ale_m;
      chk("rnd_op_ready", 32'(op_ready), 32'(e_ready));
      chk("rnd_req", 32'(bus.req), 32'(pend_v));
      chk("rnd_wr", 32'(bus.wr), pend_v ? 32'(pend_store) : 32'd0);
      chk("rnd_size", 32'(bus.size), pend_v ? 32'(pend_size) : 32'd0);
      chk("rnd_addr", bus.addr, pend_v ? pend_addr : 32'd0);
      chk("rnd_wstrb", 32'(bus.wstrb), pend_v ? 32'(strb_of(pend_store, pend_size, pend_addr)) : 32'd0);
      chk("rnd_wdata", bus.wdata, pend_v ? lane_of(pend_store, pend_size, pend_wdata) : 32'd0);
      chk("rnd_resp_valid", 32'(resp_valid), 32'(e_resp));
      chk("rnd_resp_ale", 32'(resp_ale), 32'(ale_m));
      if (bus.data_ok && !ale_m) chk("rnd_resp_rdata", resp_rdata, bus.rdata);
      chk("rnd_outstanding", 32'(dbg_outstanding), 32'(exp_q.size()));
      chk("rnd_discard", 32'(dbg_discard), 32'(killed + int'(pend_v && pend_k)));

      // advance the model across the coming clock edge
      fire = op_valid && e_ready;
      if (bus.data_ok) void'(exp_q.pop_front());
      if (pend_v && bus.addr_ok) begin
        exp_q.push_back(pend_k ? 1'b0 : 1'b1);
        pend_v = 0;
      end
      if (flush) begin
        foreach (exp_q[j]) exp_q[j] = 1'b0;
        if (pend_v) pend_k = 1;
      end
      ale_m = fire && mis;
      if (fire && !mis) begin
        pend_v = 1; pend_k = 0;
        pend_store = op_store; pend_size = op_size;
        pend_addr = op_addr; pend_wdata = op_wdata;
      end
      tick();
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
